// File: rtl/mst_data_gen_if.sv
// Pattern stream from the data generator to its consumer: one word per handshake, tagged
// with the logical channel it belongs to.
interface mst_data_gen_if #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_CH   = 2
);
    // A word transfers on every clk edge where tvalid & tready are both high. Once tvalid
    // rises, the master holds tvalid, tdata and tch unchanged until that transfer happens.
    logic                  tvalid;
    logic                  tready;
    logic [WIDTH_DATA-1:0] tdata;
    logic [WIDTH_CH-1:0]   tch;

    modport master (output tvalid, tdata, tch, input tready);
    modport slave  (input tvalid, tdata, tch, output tready);
endinterface

// File: rtl/mst_data_gen.sv
// Multi-channel incrementing-pattern generator. It serves the enabled channels round-robin
// in bursts, and it can corrupt a single word on request to exercise the checker's error path.
module mst_data_gen #(
    parameter int CNT_CHANNLS = 4,
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_LEN   = 16,
    parameter int BURST       = 8,
    localparam int WIDTH_CH   = (CNT_CHANNLS > 1) ? $clog2(CNT_CHANNLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bus16,
    input  logic                   start,
    input  logic [WIDTH_LEN-1:0]   len,
    input  logic [CNT_CHANNLS-1:0] ch_en,
    input  logic                   err_inj,
    mst_data_gen_if.master         st,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    localparam int WIDTH_BURST = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH_DATA-1:0]  cnt [CNT_CHANNLS];
    logic [WIDTH_LEN-1:0]   rem [CNT_CHANNLS];
    logic [WIDTH_CH-1:0]    last;
    logic [WIDTH_CH-1:0]    sel;
    logic                   sel_ok;
    logic [WIDTH_CH-1:0]    tch_r;
    logic [WIDTH_DATA-1:0]  tdata_r;
    logic                   tvalid_r;
    logic                   tcorr_r;
    logic                   pend;
    logic                   pend_nx;
    logic                   bus16_r;
    logic [WIDTH_BURST-1:0] burst_cnt;

    logic                   hs;
    logic [WIDTH_DATA-1:0]  cur_nxt;
    logic                   last_word;
    logic                   burst_end;
    logic                   arb_load;
    logic                   send_load;
    int                     cand;
    logic [WIDTH_CH-1:0]    cidx;

    function automatic logic [WIDTH_DATA-1:0] present(input logic [WIDTH_DATA-1:0] c,
                                                      input logic                  b16);
        logic [WIDTH_DATA-1:0] w;
        w = c;
        if (b16) begin
            w       = '0;
            w[15:0] = c[15:0];
        end
        return w;
    endfunction

    // In 16-bit mode the counter wraps at 16'hFFFF and its upper bits are forced to zero.
    function automatic logic [WIDTH_DATA-1:0] next_count(input logic [WIDTH_DATA-1:0] c,
                                                         input logic                  b16);
        logic [WIDTH_DATA-1:0] n;
        n = c + WIDTH_DATA'(1);
        if (b16) begin
            n       = '0;
            n[15:0] = c[15:0] + 16'd1;
        end
        return n;
    endfunction

    assign hs        = tvalid_r & st.tready;
    assign cur_nxt   = next_count(cnt[tch_r], bus16_r);
    assign last_word = (rem[tch_r] == WIDTH_LEN'(1));
    assign burst_end = (burst_cnt == WIDTH_BURST'(BURST - 1));
    assign arb_load  = (state == S_ARB) && sel_ok;
    assign send_load = hs && (state_nx == S_SEND);

    // The corruption request stays pending until the corrupted word itself is accepted.
    // Any word loaded while the request is pending carries the flipped bit 0.
    assign pend_nx = pend ? ~(hs & tcorr_r) : err_inj;

    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        cand   = 0;
        cidx   = '0;
        for (int k = 1; k <= CNT_CHANNLS; k++) begin
            cand = int'(last) + k;
            if (cand >= CNT_CHANNLS) cand = cand - CNT_CHANNLS;
            cidx = WIDTH_CH'(cand);
            if (!sel_ok && (rem[cidx] != '0)) begin
                sel_ok = 1'b1;
                sel    = cidx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ARB;
            S_ARB:   state_nx = sel_ok ? S_SEND : S_DONE;
            S_SEND:  if (hs && (last_word || burst_end)) state_nx = S_ARB;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CNT_CHANNLS; i++) begin
                cnt[i] <= '0;
                rem[i] <= '0;
            end
            last      <= WIDTH_CH'(CNT_CHANNLS - 1);
            tch_r     <= '0;
            tdata_r   <= '0;
            tvalid_r  <= 1'b0;
            tcorr_r   <= 1'b0;
            pend      <= 1'b0;
            bus16_r   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            tvalid_r <= (state_nx == S_SEND);
            pend     <= pend_nx;
            if ((state == S_IDLE) && start) begin
                bus16_r <= bus16;
                for (int i = 0; i < CNT_CHANNLS; i++) begin
                    rem[i] <= ch_en[i] ? len : '0;
                end
            end
            if (hs) begin
                cnt[tch_r] <= cur_nxt;
                rem[tch_r] <= rem[tch_r] - WIDTH_LEN'(1);
                burst_cnt  <= burst_cnt + WIDTH_BURST'(1);
            end
            // Output words are registered one step ahead, so each new word is built from
            // the counter value it will have after the transfer that is happening now.
            if (arb_load) begin
                last      <= sel;
                tch_r     <= sel;
                burst_cnt <= '0;
                tdata_r   <= present(cnt[sel], bus16_r) ^ WIDTH_DATA'(pend_nx);
                tcorr_r   <= pend_nx;
            end else if (send_load) begin
                tdata_r <= present(cur_nxt, bus16_r) ^ WIDTH_DATA'(pend_nx);
                tcorr_r <= pend_nx;
            end
        end
    end

    assign st.tvalid = tvalid_r;
    assign st.tdata  = tdata_r;
    assign st.tch    = tch_r;

endmodule

// File: doc/mst_data_gen.md
# mst_data_gen

Multi-channel streaming test-pattern generator for the FTDI 60x master data path. It produces the per-channel incrementing word sequence that the receive-side sequence checker expects, one channel at a time, over a valid/ready stream. Channels are served round-robin in bursts. A one-shot error-injection input corrupts exactly one word so the checker's error path can be exercised.

## Interface
- CNT_CHANNLS, 4, number of logical channels (1..8)
- WIDTH_DATA, 32, stream data width
- WIDTH_LEN, 16, width of per-channel word count
- BURST, 8, max words sent on one channel before rotating (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus16  in  1  1 = 16-bit pattern mode; sampled at start, held for the run
- start  in  1  run request pulse; accepted only in IDLE
- len  in  WIDTH_LEN  words per enabled channel; sampled at start
- ch_en  in  CNT_CHANNLS  channel enable mask; sampled at start
- err_inj  in  1  pulse: corrupt the next word handed over
- tready  in  1  downstream accepts word
- tvalid  out  1  word valid
- tdata  out  WIDTH_DATA  pattern word
- tch  out  max(1,$clog2(CNT_CHANNLS))  channel of current word
- busy  out  1  run in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse at end of run

## Operation
- Per-channel pattern counter cnt[i], WIDTH_DATA bits, reset 0 only by rst_n; persists across runs, matching the checker's free-running expectation.
- Word value for channel i: bus16=1 → {16'h0000, cnt[i][15:0]}; bus16=0 → cnt[i].
- On each handshake (tvalid & tready) cnt[tch] advances: bus16=1 → 16'hFFFF wraps to 0, upper bits forced 0; bus16=0 → all-ones wraps to 0.
- Per-channel remaining counter rem[i], WIDTH_LEN bits: at accepted start rem[i] = ch_en[i] ? len : 0; decrements by 1 on each handshake on that channel.
- FSM:
  - IDLE: start → latch bus16/len/ch_en → ARB.
  - ARB: select the first channel with rem>0 searching from (last+1) mod CNT_CHANNLS; none → DONE; else load burst counter = 0 → SEND. tvalid=0 in ARB.
  - SEND: tvalid=1, tch=selected channel. On handshake: if rem reaches 0 or burst count reaches BURST-1 → ARB, else stay.
  - DONE: done=1 for one cycle → IDLE.
- err_inj sets a sticky pending flag (ignored if already pending). The word transferred on the next handshake has tdata[0] inverted; cnt still advances normally; flag clears on that handshake. The pending flag survives across runs until consumed.
- start while busy is ignored; len/ch_en changes mid-run have no effect.
- len=0 or ch_en=0: run completes with no words (IDLE→ARB→DONE).

## Timing
- Reset values: tvalid=0, tdata=0, tch=0, busy=0, done=0, all cnt/rem=0, last channel = CNT_CHANNLS-1 (first pick is channel 0), err flag=0, state IDLE.
- start at cycle N → ARB at N+1 → first tvalid at N+2.
- Within a burst, one word per cycle while tready=1 (no bubbles).
- Each burst boundary inserts exactly one tvalid=0 cycle (ARB).
- tvalid, tdata, tch are registered and held stable while tvalid & !tready; tvalid never drops without a handshake.
- done asserts the cycle after the ARB that finds no remaining work; busy falls in the same cycle done falls.
- rst_n asserted mid-run: all state returns to reset values immediately; no done pulse.

## Test plan
- Single channel: ch_en=4'b0001, len=3, bus16=0, tready=1 → tdata 0,1,2 on tch=0 in cycles N+2..N+4; done at N+6; second run → 3,4,5.
- Round robin: ch_en=4'b1111, len=10, BURST=8 → ch0 ×8, ch1 ×8, ch2 ×8, ch3 ×8, ch0 ×2, …, ch3 ×2; 40 words total; ARB bubble between each burst.
- Wrap, bus16=1: preload ch0 by running len=65535, then len=2 → words 16'hFFFF then 16'h0000 with tdata[31:16]=0.
- Backpressure: tready random 50% → tdata/tch stable while stalled; sequence per channel gapless; checker sees no error.
- Error injection: err_inj pulse before word 5 of ch0 → tdata = 5^1 = 4 on that word, next word 6; checker flags ch0 only.
- Edge/reset: len=0 → done at N+2, no tvalid; rst_n low mid-burst → tvalid=0, busy=0, next run restarts at 0.
